// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration-time helpers for the parametrised sync FIFO.
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int unsigned fifo_aw(input int unsigned depth);
    int unsigned aw;
    aw = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < depth) aw = i + 1;
    end
    return aw;
  endfunction

  function automatic bit fifo_params_ok(input int unsigned depth,
                                        input int unsigned pf,
                                        input int unsigned pe);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (pf >= 1) && (pf <= depth) && (pe <= depth - 1);
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Write/read handshake and status bundle for param_sync_fifo.
interface param_sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned CW = fifo_aw(DEPTH) + 1;

  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             full;
  logic             empty;
  logic             prog_full;
  logic             prog_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, valid, full, empty, prog_full, prog_empty, count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, valid, full, empty, prog_full, prog_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read (distributed RAM model).
module sync_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with FWFT/standard read modes, programmable thresholds and error pulses.
module param_sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned FWFT     = 1,
  parameter int unsigned PF_VALUE = 28,
  parameter int unsigned PE_VALUE = 2
) (
  input logic               clk,
  input logic               rst,
  param_sync_fifo_if.slave  bus
);
  localparam int unsigned AW = fifo_aw(DEPTH);
  localparam logic [AW:0] PF_C = PF_VALUE[AW:0];
  localparam logic [AW:0] PE_C = PE_VALUE[AW:0];

  if (!fifo_params_ok(DEPTH, PF_VALUE, PE_VALUE)) begin : g_bad_params
    $fatal(1, "param_sync_fifo: DEPTH must be a power of 2 >= 4, PF_VALUE in 1..DEPTH, PE_VALUE in 0..DEPTH-1");
  end

  logic [AW:0]      wptr, rptr, count;
  logic             full, empty, wr_acc, rd_acc;
  logic             overflow_q, underflow_q;
  logic [WIDTH-1:0] rdata;

  assign count  = wptr - rptr;
  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & ~empty;

  sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[AW-1:0]),
    .wdata (bus.din),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      overflow_q  <= bus.wr_en & full;
      underflow_q <= bus.rd_en & empty;
    end
  end

  if (FWFT == 32'(FIFO_MODE_FWFT)) begin : g_fwft
    assign bus.dout  = rdata;
    assign bus.valid = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) dout_q <= rdata;
      end
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
  end

  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.prog_full  = (count >= PF_C);
  assign bus.prog_empty = (count <= PE_C);
  assign bus.count      = count;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: one FWFT instance and one standard-mode instance.
module tb_param_sync_fifo;
  import sync_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] exp_f[$];
  logic [7:0] exp_s[$];

  always #5 clk = ~clk;

  param_sync_fifo_if #(.WIDTH(8), .DEPTH(16)) f ();
  param_sync_fifo_if #(.WIDTH(8), .DEPTH(16)) s ();

  param_sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1), .PF_VALUE(12), .PE_VALUE(2)) u_fwft (
    .clk (clk), .rst (rst), .bus (f)
  );

  param_sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(0), .PF_VALUE(12), .PE_VALUE(2)) u_std (
    .clk (clk), .rst (rst), .bus (s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // FWFT: a word is consumed on the edge where valid & rd_en
  always @(negedge clk) begin
    if (!rst && f.valid && f.rd_en) begin
      if (exp_f.size() == 0) chk("fwft_unexpected_pop", 32'(f.dout), 32'hFFFF_FFFF);
      else chk("fwft_dout", 32'(f.dout), 32'(exp_f.pop_front()));
    end
  end

  // STD: valid marks the registered read result
  always @(negedge clk) begin
    if (!rst && s.valid) begin
      if (exp_s.size() == 0) chk("std_unexpected_valid", 32'(s.dout), 32'hFFFF_FFFF);
      else chk("std_dout", 32'(s.dout), 32'(exp_s.pop_front()));
    end
  end

  initial begin
    f.din = '0; f.wr_en = 1'b0; f.rd_en = 1'b0;
    s.din = '0; s.wr_en = 1'b0; s.rd_en = 1'b0;

    // reset / idle
    repeat (3) step();
    rst = 1'b0;
    chk("rst_empty",      32'(f.empty), 32'd1);
    chk("rst_prog_empty", 32'(f.prog_empty), 32'd1);
    chk("rst_full",       32'(f.full), 32'd0);
    chk("rst_prog_full",  32'(f.prog_full), 32'd0);
    chk("rst_count",      32'(f.count), 32'd0);
    chk("rst_valid",      32'(f.valid), 32'd0);
    chk("rst_overflow",   32'(f.overflow), 32'd0);
    chk("rst_underflow",  32'(f.underflow), 32'd0);
    chk("rst_std_valid",  32'(s.valid), 32'd0);
    chk("rst_std_dout",   32'(s.dout), 32'd0);

    // fill to full
    for (int i = 0; i < 16; i++) begin
      f.din = 8'(i); f.wr_en = 1'b1; exp_f.push_back(8'(i));
      step();
      chk("fill_count",      32'(f.count), 32'(i + 1));
      chk("fill_prog_empty", 32'(f.prog_empty), 32'((i + 1) <= 2));
      chk("fill_prog_full",  32'(f.prog_full), 32'((i + 1) >= 12));
      chk("fill_full",       32'(f.full), 32'((i + 1) == 16));
    end
    f.din = 8'hEE;
    step();
    chk("ovf_pulse", 32'(f.overflow), 32'd1);
    chk("ovf_count", 32'(f.count), 32'd16);
    f.wr_en = 1'b0;
    step();
    chk("ovf_clear", 32'(f.overflow), 32'd0);

    // drain and order
    f.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("drain_count", 32'(f.count), 32'(15 - i));
    end
    chk("drain_valid", 32'(f.valid), 32'd0);
    chk("drain_empty", 32'(f.empty), 32'd1);
    step();
    chk("unf_pulse", 32'(f.underflow), 32'd1);
    f.rd_en = 1'b0;
    step();
    chk("unf_clear", 32'(f.underflow), 32'd0);

    // simultaneous read/write at count=5 across pointer wraps
    f.wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f.din = 8'(8'h10 + i); exp_f.push_back(8'(8'h10 + i));
      step();
    end
    chk("sim_pre_count", 32'(f.count), 32'd5);
    f.rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      f.din = 8'(8'h15 + i); exp_f.push_back(8'(8'h15 + i));
      step();
      chk("sim_count", 32'(f.count), 32'd5);
    end
    f.wr_en = 1'b0;
    repeat (5) step();
    f.rd_en = 1'b0;
    chk("sim_drained", 32'(f.count), 32'd0);

    // wr&rd at full: read wins, write dropped
    f.wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      f.din = 8'(8'h40 + i); exp_f.push_back(8'(8'h40 + i));
      step();
    end
    chk("full2_full", 32'(f.full), 32'd1);
    f.din = 8'hFF; f.rd_en = 1'b1;
    step();
    chk("full_rw_count", 32'(f.count), 32'd15);
    chk("full_rw_ovf",   32'(f.overflow), 32'd1);
    f.wr_en = 1'b0;
    repeat (15) step();
    chk("full_rw_drained", 32'(f.count), 32'd0);

    // wr&rd at empty: write wins, read rejected
    f.wr_en = 1'b1; f.din = 8'h77; exp_f.push_back(8'h77);
    step();
    chk("empty_rw_count", 32'(f.count), 32'd1);
    chk("empty_rw_unf",   32'(f.underflow), 32'd1);
    f.wr_en = 1'b0;
    step();
    f.rd_en = 1'b0;
    chk("empty_rw_drained", 32'(f.count), 32'd0);

    // reset mid-operation with a concurrent write
    f.wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      f.din = 8'(8'h80 + i);
      step();
    end
    chk("pre_rst_count", 32'(f.count), 32'd9);
    rst = 1'b1; f.din = 8'h99;
    step();
    rst = 1'b0; f.wr_en = 1'b0;
    chk("mid_rst_count", 32'(f.count), 32'd0);
    chk("mid_rst_empty", 32'(f.empty), 32'd1);
    chk("mid_rst_valid", 32'(f.valid), 32'd0);
    f.wr_en = 1'b1; f.din = 8'h5A; exp_f.push_back(8'h5A);
    step();
    f.wr_en = 1'b0; f.rd_en = 1'b1;
    step();
    f.rd_en = 1'b0;
    chk("post_rst_count", 32'(f.count), 32'd0);

    // standard-mode latency
    s.wr_en = 1'b1; s.din = 8'hA5;
    step();
    s.wr_en = 1'b0; s.rd_en = 1'b1; exp_s.push_back(8'hA5);
    chk("std_pre_valid", 32'(s.valid), 32'd0);
    step();
    s.rd_en = 1'b0;
    chk("std_valid", 32'(s.valid), 32'd1);
    step();
    chk("std_valid_drop", 32'(s.valid), 32'd0);
    chk("std_dout_hold",  32'(s.dout), 32'hA5);
    s.wr_en = 1'b1; s.din = 8'h3C;
    step();
    s.din = 8'hC3;
    step();
    s.wr_en = 1'b0; s.rd_en = 1'b1;
    exp_s.push_back(8'h3C); exp_s.push_back(8'hC3);
    repeat (2) step();
    s.rd_en = 1'b0;
    step();
    chk("std_empty", 32'(s.empty), 32'd1);

    chk("fwft_sb_empty", 32'(exp_f.size()), 32'd0);
    chk("std_sb_empty",  32'(exp_s.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Single-clock FIFO, the parametrised successor to the team's fixed 32-deep distributed-RAM sync FIFO. Adds these over the fixed version:
- Generic WIDTH and power-of-2 DEPTH.
- Selectable first-word-fall-through (FWFT) or standard (registered-read) mode.
- Programmable full and empty thresholds.
- Exact occupancy count.
- Sticky-free overflow/underflow error pulses.

It sits between pixel/line producers and consumers in the video pipeline, wherever a shallow same-clock elastic buffer is needed.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 32, number of entries; power of 2, >=4; AW = clog2(DEPTH)
FWFT, 1, 1 = first-word-fall-through; 0 = standard mode (dout registered, one cycle after rd_en)
PF_VALUE, 28, prog_full asserts when count >= PF_VALUE; legal 1..DEPTH
PE_VALUE, 2, prog_empty asserts when count <= PE_VALUE; legal 0..DEPTH-1

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
din  in  WIDTH  write data
wr_en  in  1  write request
rd_en  in  1  read request (FWFT: acknowledge of the current dout)
dout  out  WIDTH  read data
valid  out  1  dout holds valid data
full  out  1  count == DEPTH
empty  out  1  count == 0
prog_full  out  1  count >= PF_VALUE
prog_empty  out  1  count <= PE_VALUE
count  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: previous-cycle wr_en rejected
underflow  out  1  one-cycle pulse: previous-cycle rd_en rejected

Behaviour:
- Reset (rst=1 at clk edge):
  - Pointers, count, overflow and underflow go to 0.
  - empty=1, prog_empty=1, full=0, prog_full=0, valid=0.
  - STD mode: dout register goes to 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data; the first cycle after reset behaves as freshly empty.
- Pointers are AW+1 bits (wrap bit plus index); count = wptr - rptr (modulo 2^(AW+1)).
- full, empty, prog_full, prog_empty, count are combinational from the registered pointers. No extra latency.
- Write accepted iff wr_en & ~full. Read accepted iff rd_en & ~empty. Both use current-cycle flags.
- Simultaneous accepted read and write: count unchanged; both pointers advance.
- Full with wr_en & rd_en: read accepted, write dropped, overflow pulses next cycle. No write-through into the slot being freed.
- Empty with wr_en & rd_en: write accepted, read rejected, underflow pulses next cycle.
- overflow/underflow are registered; they go high for exactly one cycle per rejected request.
- Write-to-read latency:
  - FWFT: a word written at edge N appears on dout with valid=1 after edge N.
  - STD: first rd_en accepted at edge N+1 or later; data appears after the following edge.
- FWFT mode:
  - dout = mem[rptr] (asynchronous read); valid = ~empty.
  - rd_en pops the word; the next word, if any, is on dout in the same cycle after the edge.
  - dout is don't-care while valid=0.
- STD mode:
  - On an accepted read, dout <= mem[rptr] and valid <= 1 at that edge.
  - Otherwise valid <= 0 and dout holds its last value.
  - Read latency is 1 cycle.
- Wrap-around: index bits wrap at DEPTH; the wrap bit toggles. full = index equal & wrap differs; empty = pointers equal.
- Parameter legality is checked at elaboration: assertion/fatal on non-power-of-2 DEPTH or out-of-range PF_VALUE/PE_VALUE.

Decomposition:
- Package sync_fifo_pkg holds:
  - clog2-style function fifo_aw(depth).
  - Mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1.
  - Parameter-check helper function.
- Sub-module sync_fifo_mem (WIDTH, DEPTH):
  - Simple dual-port distributed RAM with sync write (clk, we, waddr, wdata) and async read (raddr, rdata).
  - Isolates vendor primitives per device family behind one behavioural model.
- Pointer/flag/mode logic lives in param_sync_fifo.

Test Plan:
- Reset/idle: rst 3 cycles, WIDTH=8, DEPTH=16, PF=12, PE=2 -> empty=1, prog_empty=1, full=0, prog_full=0, count=0, valid=0, overflow=underflow=0.
- Fill to full (FWFT): write 0x00..0x0F on 16 consecutive cycles:
  - prog_empty drops when count=3.
  - prog_full rises when count=12.
  - full=1 and count=16 after the 16th write.
  - A 17th wr_en gives overflow=1 for one cycle and count stays 16.
- Drain and order (FWFT): from full, hold rd_en 16 cycles -> dout sequence 0x00..0x0F, valid deasserts with empty after the last; an extra rd_en gives a underflow pulse.
- STD latency: FWFT=0; write 0xA5 then rd_en next cycle -> valid=1 with dout=0xA5 exactly one cycle after rd_en; dout holds 0xA5 after valid drops.
- Simultaneous ops and wrap:
  - At count=5, wr_en & rd_en for 40 cycles with an incrementing pattern -> count stays 5, data in order across several pointer wraps.
  - At full, wr_en & rd_en -> count becomes 15, overflow=1.
  - At empty, wr_en & rd_en -> count becomes 1, underflow=1.
- Reset mid-operation: at count=9, assert rst one cycle with wr_en=1 -> count=0, empty=1 next cycle, write not stored; a subsequent write/read returns only new data.
